// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan multiplexer.
// Vectors are passed at the widest supported size (8 digits) and narrowed by callers.
package seg7_pkg;

    localparam int   DIGIT_W    = 4;
    localparam int   MAX_DIGITS = 8;
    localparam logic AN_OFF     = 1'b1;
    localparam logic DP_OFF     = 1'b1;

    function automatic logic [DIGIT_W-1:0] nibble_of(
        input logic [DIGIT_W*MAX_DIGITS-1:0] vec,
        input int                            idx
    );
        return vec[idx*DIGIT_W +: DIGIT_W];
    endfunction

    // Bit i is set when digit i and every digit above it (below n) are zero; bit 0 never set.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [DIGIT_W*MAX_DIGITS-1:0] vec,
        input int                            n
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  allZero;
        mask    = '0;
        allZero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                allZero = allZero && (vec[i*DIGIT_W +: DIGIT_W] == '0);
                mask[i] = allZero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_slot_timer.sv
// Per-digit slot counter: flags the last cycle of each slot and the leading dead window.
module slot_timer #(
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    output logic o_wrap,
    output logic o_inDead
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    logic [CNT_W-1:0] r_count;

    assign o_wrap   = (r_count == CNT_W'(SLOT_CYCLES - 1));
    assign o_inDead = (r_count <  CNT_W'(DEAD_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex display scanner: digit index, double-buffered snapshot,
// leading-zero blanking and registered active-low anode / decimal-point drive.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_blank,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int VAL_W  = DIGIT_W * NUM_DIGITS;
    localparam int WIDE_W = DIGIT_W * MAX_DIGITS;

    logic                  w_wrap;
    logic                  w_inDead;
    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_shadowVal;
    logic [VAL_W-1:0]      r_activeVal;
    logic [NUM_DIGITS-1:0] r_shadowDp;
    logic [NUM_DIGITS-1:0] r_activeDp;
    logic                  r_pending;
    logic [WIDE_W-1:0]     w_activeWide;
    logic [NUM_DIGITS-1:0] w_lzMask;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_anOn;

    slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slotTimer (
        .clk      (clk),
        .rst      (rst),
        .o_wrap   (w_wrap),
        .o_inDead (w_inDead)
    );

    assign w_activeWide = WIDE_W'(r_activeVal);
    assign w_lzMask     = NUM_DIGITS'(lz_mask(w_activeWide, NUM_DIGITS));
    assign w_blank      = lz_blank && w_lzMask[r_idx];
    assign w_anOn       = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Active snapshot swaps only at slot boundaries; a load on that same edge
    // lands in the shadow and stays pending for the following boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_activeVal <= '0;
            r_activeDp  <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_activeVal <= r_shadowVal;
                r_activeDp  <= r_shadowDp;
                r_pending   <= 1'b0;
            end
            if (load) begin
                r_shadowVal <= value;
                r_shadowDp  <= dp_in;
                r_pending   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= {NUM_DIGITS{AN_OFF}};
            digit      <= '0;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= (w_inDead || w_blank) ? {NUM_DIGITS{AN_OFF}} : w_anOn;
            digit      <= nibble_of(w_activeWide, int'(r_idx));
            dp         <= w_blank ? DP_OFF : ~r_activeDp[r_idx];
            frame_done <= w_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised self-checking bench for seg7_scan_mux against a cycle-count based reference model.
module tb_seg7_scan_mux;

    localparam int N    = 4;
    localparam int SLOT = 8;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  digit;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the scan derived purely from edges since reset.
    int          mCyc;
    logic [15:0] mShadow, mActive;
    logic [3:0]  mShadowDp, mActiveDp;
    bit          mPending;
    logic [3:0]  expDigit, expAn;
    logic        expDp, expFrame;

    seg7_scan_mux #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (SLOT),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .digit      (digit),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic resetModel();
        mCyc      = 0;
        mShadow   = '0;
        mActive   = '0;
        mShadowDp = '0;
        mActiveDp = '0;
        mPending  = 1'b0;
    endtask

    // Drives one cycle of inputs, predicts the outputs after the coming edge, advances the model.
    task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
        int          pos, ix;
        logic        blank;
        logic [15:0] upper;
        load     = ld;
        value    = v;
        dp_in    = d;
        lz_blank = lz;
        pos      = mCyc % SLOT;
        ix       = (mCyc / SLOT) % N;
        upper    = mActive >> (4 * ix);
        blank    = lz && (ix > 0) && (upper == 16'h0);
        expDigit = upper[3:0];
        expAn    = (pos < DEAD || blank) ? 4'hF : (4'hF & ~(4'b0001 << ix));
        expDp    = blank ? 1'b1 : ~mActiveDp[ix];
        expFrame = (pos == SLOT - 1) && (ix == N - 1);
        if (pos == SLOT - 1 && mPending) begin
            mActive   = mShadow;
            mActiveDp = mShadowDp;
            mPending  = 1'b0;
        end
        if (ld) begin
            mShadow   = v;
            mShadowDp = d;
            mPending  = 1'b1;
        end
        mCyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({digit, an, dp, frame_done} !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset: got digit=%h an=%b dp=%b fd=%b, expected digit=0 an=1111 dp=1 fd=0",
                     digit, an, dp, frame_done);
        end
        rst = 1'b0;
        resetModel();
    endtask

    task automatic test_basic();
        int fdCount = 0;
        tick(1'b1, 16'h12AF, 4'b0100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL basic cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
            if (i >= 32) fdCount += int'(frame_done);
        end
        checks++;
        if (fdCount != 1) begin
            errors++;
            $display("[TB] FAIL frame_rate: got %0d frame_done pulses in 32 cycles, expected 1", fdCount);
        end
    endtask

    task automatic test_lz_blank(input logic [15:0] v);
        tick(1'b1, v, 4'b1111, 1'b1);
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b1);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL lz_blank v=%h cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         v, mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seenOne = 1'b0;
        for (int i = 0; i < SLOT && (mCyc % SLOT) != 2; i++) tick(1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b1, 16'h1111, 4'b0000, 1'b0);
        tick(1'b1, 16'h2222, 4'b0000, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
            if (digit == 4'h1) seenOne = 1'b1;
        end
        checks++;
        if (seenOne) begin
            errors++;
            $display("[TB] FAIL overwritten_load: got digit 1 on the display, expected it never to appear");
        end
    endtask

    task automatic test_wrap_collision();
        for (int i = 0; i < SLOT && (mCyc % SLOT) != 5; i++) tick(1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b1, 16'h3333, 4'b0001, 1'b0);
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b1, 16'h4444, 4'b0010, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL wrap_collision cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
        end
    endtask

    task automatic test_random();
        logic        lz = 1'b0;
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            tick(($urandom_range(0, 9) == 0), 16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom), lz);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 16'h9876, 4'b1111, 1'b0);
        for (int i = 0; i < 64 && (mCyc % (SLOT * N)) != 2 * SLOT + 5; i++) tick(1'b0, 16'h0, 4'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({digit, an, dp, frame_done} !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid: got digit=%h an=%b dp=%b fd=%b, expected digit=0 an=1111 dp=1 fd=0",
                     digit, an, dp, frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            checks++;
            if ({digit, an, dp, frame_done} !== {expDigit, expAn, expDp, expFrame}) begin
                errors++;
                $display("[TB] FAIL after_reset cyc=%0d: got digit=%h an=%b dp=%b fd=%b, expected digit=%h an=%b dp=%b fd=%b",
                         mCyc, digit, an, dp, frame_done, expDigit, expAn, expDp, expFrame);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz_blank(16'h0005);
        test_lz_blank(16'h0000);
        test_lz_blank(16'h0300);
        test_back_to_back();
        test_wrap_collision();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
